// File: rtl/axil_stream_pktgen.sv
// axil_stream_pktgen: AXI4-Lite programmable generator of incrementing AXI4-Stream packets
module axil_stream_pktgen #(
   parameter int C_S_AXI_DATA_WIDTH   = 32,
   parameter int C_S_AXI_ADDR_WIDTH   = 5,
   parameter int NUM_REGS             = 8,
   parameter int C_M_AXIS_TDATA_WIDTH = 32,
   parameter int DATA_INCR            = 1
) (
   input  logic                                ACLK,
   input  logic                                ARESETN,
   input  logic [C_S_AXI_ADDR_WIDTH-1:0]       S_AXI_AWADDR,
   input  logic                                S_AXI_AWVALID,
   output logic                                S_AXI_AWREADY,
   input  logic [C_S_AXI_DATA_WIDTH-1:0]       S_AXI_WDATA,
   input  logic [C_S_AXI_DATA_WIDTH/8-1:0]     S_AXI_WSTRB,
   input  logic                                S_AXI_WVALID,
   output logic                                S_AXI_WREADY,
   output logic [1:0]                          S_AXI_BRESP,
   output logic                                S_AXI_BVALID,
   input  logic                                S_AXI_BREADY,
   input  logic [C_S_AXI_ADDR_WIDTH-1:0]       S_AXI_ARADDR,
   input  logic                                S_AXI_ARVALID,
   output logic                                S_AXI_ARREADY,
   output logic [C_S_AXI_DATA_WIDTH-1:0]       S_AXI_RDATA,
   output logic [1:0]                          S_AXI_RRESP,
   output logic                                S_AXI_RVALID,
   input  logic                                S_AXI_RREADY,
   output logic [C_M_AXIS_TDATA_WIDTH-1:0]     M_AXIS_TDATA,
   output logic [C_M_AXIS_TDATA_WIDTH/8-1:0]   M_AXIS_TKEEP,
   output logic                                M_AXIS_TLAST,
   output logic                                M_AXIS_TVALID,
   input  logic                                M_AXIS_TREADY
);
   localparam int IW = C_S_AXI_ADDR_WIDTH - 2;
   localparam int RW = $clog2(NUM_REGS);
   localparam int TW = C_M_AXIS_TDATA_WIDTH;
   typedef enum logic {IDLE, RUN} state_t;
   state_t state;
   logic [31:0] regs [NUM_REGS];
   logic cont, abort_p;
   logic [31:0] len_l, cnt, eff_len, rd_val;
   logic [15:0] pkt_cnt;
   logic [IW-1:0] wr_idx, rd_idx;
   logic [TW-1:0] seed;
   logic wr_fire, wr_ok, rd_ok, ctrl_wr, start, abort_now, hs, unused;

   assign wr_idx    = S_AXI_AWADDR[C_S_AXI_ADDR_WIDTH-1:2];
   assign rd_idx    = S_AXI_ARADDR[C_S_AXI_ADDR_WIDTH-1:2];
   assign wr_fire   = S_AXI_AWREADY & S_AXI_AWVALID & S_AXI_WREADY & S_AXI_WVALID;
   assign wr_ok     = {{(32-IW){1'b0}}, wr_idx} < NUM_REGS;
   assign rd_ok     = {{(32-IW){1'b0}}, rd_idx} < NUM_REGS;
   assign ctrl_wr   = wr_fire & (wr_idx == '0) & S_AXI_WSTRB[0];
   assign start     = ctrl_wr & S_AXI_WDATA[0] & (state == IDLE);
   assign abort_now = ctrl_wr & S_AXI_WDATA[2] & (state == RUN);
   assign hs        = M_AXIS_TVALID & M_AXIS_TREADY;
   assign eff_len   = (regs[1] == 32'd0) ? 32'd1 : regs[1];
   assign seed      = TW'(regs[2]);
   assign M_AXIS_TKEEP = '1;
   assign unused    = ^{S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

   // Read mux: CTRL exposes only CONT, STATUS is synthesised from live state
   always_comb
      rd_val = !rd_ok ? 32'd0 :
               (rd_idx == '0) ? {30'd0, cont, 1'b0} :
               (rd_idx == IW'(3)) ? {pkt_cnt, 15'd0, state == RUN} :
               regs[rd_idx[RW-1:0]];

   // Write channel and register bank; START/ABORT are pulses, never stored
   always_ff @(posedge ACLK or negedge ARESETN)
      if (!ARESETN) begin
         S_AXI_AWREADY <= 1'b0;
         S_AXI_WREADY  <= 1'b0;
         S_AXI_BVALID  <= 1'b0;
         S_AXI_BRESP   <= 2'b00;
         cont          <= 1'b0;
         for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
      end else begin
         S_AXI_AWREADY <= S_AXI_AWVALID & S_AXI_WVALID & !S_AXI_BVALID & !S_AXI_AWREADY;
         S_AXI_WREADY  <= S_AXI_AWVALID & S_AXI_WVALID & !S_AXI_BVALID & !S_AXI_AWREADY;
         if (wr_fire) begin
            S_AXI_BVALID <= 1'b1;
            S_AXI_BRESP  <= wr_ok ? 2'b00 : 2'b10;
         end else if (S_AXI_BREADY)
            S_AXI_BVALID <= 1'b0;
         for (int i = 1; i < NUM_REGS; i++)
            for (int b = 0; b < 4; b++)
               if (wr_fire && i != 3 && wr_idx == IW'(i) && S_AXI_WSTRB[b])
                  regs[i][8*b +: 8] <= S_AXI_WDATA[8*b +: 8];
         if (ctrl_wr) cont <= S_AXI_WDATA[1] & !abort_now;
      end

   // Read channel: RDATA captured at address handshake and held until RREADY
   always_ff @(posedge ACLK or negedge ARESETN)
      if (!ARESETN) begin
         S_AXI_ARREADY <= 1'b0;
         S_AXI_RVALID  <= 1'b0;
         S_AXI_RDATA   <= '0;
         S_AXI_RRESP   <= 2'b00;
      end else begin
         S_AXI_ARREADY <= S_AXI_ARVALID & !S_AXI_RVALID & !S_AXI_ARREADY;
         if (S_AXI_ARREADY && S_AXI_ARVALID) begin
            S_AXI_RVALID <= 1'b1;
            S_AXI_RDATA  <= rd_val;
            S_AXI_RRESP  <= rd_ok ? 2'b00 : 2'b10;
         end else if (S_AXI_RREADY)
            S_AXI_RVALID <= 1'b0;
      end

   // Stream FSM; TLAST is precomputed for the beat being presented
   always_ff @(posedge ACLK or negedge ARESETN)
      if (!ARESETN) begin
         state         <= IDLE;
         M_AXIS_TVALID <= 1'b0;
         M_AXIS_TLAST  <= 1'b0;
         M_AXIS_TDATA  <= '0;
         len_l         <= '0;
         cnt           <= '0;
         abort_p       <= 1'b0;
         pkt_cnt       <= '0;
      end else if (state == IDLE) begin
         if (start) begin
            state         <= RUN;
            M_AXIS_TVALID <= 1'b1;
            M_AXIS_TDATA  <= seed;
            M_AXIS_TLAST  <= eff_len == 32'd1;
            len_l         <= eff_len;
            cnt           <= '0;
         end
      end else begin
         abort_p <= abort_p | abort_now;
         if (hs) begin
            M_AXIS_TDATA <= M_AXIS_TDATA + TW'(DATA_INCR);
            cnt          <= cnt + 32'd1;
            M_AXIS_TLAST <= (cnt + 32'd2 == len_l) | abort_p | abort_now;
            if (M_AXIS_TLAST) begin
               pkt_cnt <= pkt_cnt + 16'd1;
               if (cont && !abort_p && !abort_now) begin
                  M_AXIS_TDATA <= seed;
                  M_AXIS_TLAST <= eff_len == 32'd1;
                  len_l        <= eff_len;
                  cnt          <= '0;
               end else begin
                  state         <= IDLE;
                  M_AXIS_TVALID <= 1'b0;
                  M_AXIS_TLAST  <= 1'b0;
                  abort_p       <= 1'b0;
               end
            end
         end else if (abort_now)
            M_AXIS_TLAST <= 1'b1;
      end
endmodule

// File: tb/tb_axil_stream_pktgen.sv
// tb_axil_stream_pktgen: directed self-checking bench for the packet generator
module tb_axil_stream_pktgen;
   logic clk = 1'b0, rst_n;
   logic [5:0] awaddr, araddr;
   logic awvalid, awready, wvalid, wready, bvalid, bready;
   logic arvalid, arready, rvalid, rready;
   logic [31:0] wdata, rdata, tdata;
   logic [3:0] wstrb, tkeep;
   logic [1:0] bresp, rresp;
   logic tlast, tvalid, tready;
   int checks = 0, errors = 0, cyc = 0, stab_err = 0;
   logic mon_stab = 1'b0, tog = 1'b0, hold = 1'b0;
   logic [31:0] hold_d;
   logic [31:0] qd [$];
   logic ql [$];
   int qc [$];
   logic [31:0] d;
   logic [1:0] r;
   logic [31:0] exp_d [8] = '{32'h100, 32'h101, 32'h102, 32'h100, 32'h101, 32'h102, 32'h100, 32'h101};
   logic exp_l [8] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};

   axil_stream_pktgen #(.C_S_AXI_ADDR_WIDTH(6)) dut (
      .ACLK(clk), .ARESETN(rst_n),
      .S_AXI_AWADDR(awaddr), .S_AXI_AWVALID(awvalid), .S_AXI_AWREADY(awready),
      .S_AXI_WDATA(wdata), .S_AXI_WSTRB(wstrb), .S_AXI_WVALID(wvalid), .S_AXI_WREADY(wready),
      .S_AXI_BRESP(bresp), .S_AXI_BVALID(bvalid), .S_AXI_BREADY(bready),
      .S_AXI_ARADDR(araddr), .S_AXI_ARVALID(arvalid), .S_AXI_ARREADY(arready),
      .S_AXI_RDATA(rdata), .S_AXI_RRESP(rresp), .S_AXI_RVALID(rvalid), .S_AXI_RREADY(rready),
      .M_AXIS_TDATA(tdata), .M_AXIS_TKEEP(tkeep), .M_AXIS_TLAST(tlast),
      .M_AXIS_TVALID(tvalid), .M_AXIS_TREADY(tready)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   // Beat collector: a beat seen valid&ready at negedge is accepted on the next edge
   always @(negedge clk)
      if (tvalid && tready) begin
         qd.push_back(tdata);
         ql.push_back(tlast);
         qc.push_back(cyc);
      end

   // Stall stability: a presented but unaccepted beat must stay valid with the same data
   always @(negedge clk) begin
      if (mon_stab && hold && !(tvalid && tdata == hold_d)) stab_err++;
      hold   = tvalid && !tready;
      hold_d = tdata;
   end

   task automatic chk(input string tag, input logic [63:0] o, input logic [63:0] e);
      checks++;
      assert (o === e) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, o, e);
      end
   endtask

   task automatic axi_write(input logic [5:0] a, input logic [31:0] v, input logic [3:0] s, output logic [1:0] resp);
      int n;
      @(negedge clk);
      awaddr = a; wdata = v; wstrb = s; awvalid = 1'b1; wvalid = 1'b1; bready = 1'b1;
      n = 0;
      while (!awready && n < 20) begin @(negedge clk); n++; end
      if (!awready) begin errors++; $display("FAIL axi_write: no AWREADY, observed 0 expected 1"); end
      @(posedge clk); #1 awvalid = 1'b0; wvalid = 1'b0;
      n = 0;
      while (!bvalid && n < 20) begin @(negedge clk); n++; end
      if (!bvalid) begin errors++; $display("FAIL axi_write: no BVALID, observed 0 expected 1"); end
      resp = bresp;
      @(posedge clk); #1 bready = 1'b0;
   endtask

   task automatic axi_read(input logic [5:0] a, output logic [31:0] v, output logic [1:0] resp);
      int n;
      @(negedge clk);
      araddr = a; arvalid = 1'b1; rready = 1'b1;
      n = 0;
      while (!arready && n < 20) begin @(negedge clk); n++; end
      if (!arready) begin errors++; $display("FAIL axi_read: no ARREADY, observed 0 expected 1"); end
      @(posedge clk); #1 arvalid = 1'b0;
      n = 0;
      while (!rvalid && n < 20) begin @(negedge clk); n++; end
      if (!rvalid) begin errors++; $display("FAIL axi_read: no RVALID, observed 0 expected 1"); end
      v = rdata; resp = rresp;
      @(posedge clk); #1 rready = 1'b0;
   endtask

   task automatic wait_beats(input int n);
      int k = 0;
      while (qd.size() < n && k < 200) begin @(posedge clk); k++; end
      if (qd.size() < n) begin
         errors++;
         $display("FAIL wait_beats: observed %0d beats expected %0d", qd.size(), n);
      end
   endtask

   task automatic qclear();
      qd.delete(); ql.delete(); qc.delete();
   endtask

   initial begin
      rst_n = 1'b0; awaddr = '0; araddr = '0; wdata = '0; wstrb = '0;
      awvalid = 1'b0; wvalid = 1'b0; bready = 1'b0; arvalid = 1'b0; rready = 1'b0; tready = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_tvalid", tvalid, 0);
      chk("rst_tlast", tlast, 0);
      chk("rst_tdata", tdata, 0);
      chk("rst_awready", awready, 0);
      chk("rst_wready", wready, 0);
      chk("rst_bvalid", bvalid, 0);
      chk("rst_arready", arready, 0);
      chk("rst_rvalid", rvalid, 0);
      chk("rst_rdata", rdata, 0);
      chk("rst_resp", {bresp, rresp}, 0);
      chk("tkeep", tkeep, 4'hF);
      @(posedge clk); #1 rst_n = 1'b1;

      for (int i = 0; i < 4; i++) begin
         axi_write(6'(16 + 4 * i), 32'(i + 1), 4'hF, r);
         chk("scratch_bresp", r, 2'b00);
      end
      for (int i = 0; i < 4; i++) begin
         axi_read(6'(16 + 4 * i), d, r);
         chk("scratch_rdata", d, 32'(i + 1));
         chk("scratch_rresp", r, 2'b00);
      end
      axi_read(6'h20, d, r);
      chk("oor_rdata", d, 0);
      chk("oor_rresp", r, 2'b10);
      axi_write(6'h20, 32'h5, 4'hF, r);
      chk("oor_bresp", r, 2'b10);
      axi_write(6'h0C, 32'hFFFF_FFFF, 4'hF, r);
      chk("status_wr_bresp", r, 2'b00);
      axi_read(6'h0C, d, r);
      chk("status_ro", d, 0);

      axi_write(6'h18, 32'h0, 4'hF, r);
      axi_write(6'h18, 32'hAABB_CCDD, 4'b0010, r);
      axi_read(6'h18, d, r);
      chk("wstrb_byte1", d, 32'h0000_CC00);

      tready = 1'b1;
      axi_write(6'h04, 32'd4, 4'hF, r);
      axi_write(6'h08, 32'h10, 4'hF, r);
      qclear();
      axi_write(6'h00, 32'h1, 4'hF, r);
      wait_beats(4);
      repeat (5) @(posedge clk);
      chk("p1_count", qd.size(), 4);
      for (int i = 0; i < 4 && i < qd.size(); i++) begin
         chk("p1_data", qd[i], 32'h10 + 32'(i));
         chk("p1_last", ql[i], i == 3);
      end
      if (qc.size() == 4) chk("p1_back_to_back", qc[3] - qc[0], 3);
      @(negedge clk);
      chk("p1_idle_tvalid", tvalid, 0);
      axi_read(6'h0C, d, r);
      chk("p1_status", d, 32'h0001_0000);

      axi_write(6'h04, 32'd0, 4'hF, r);
      axi_write(6'h08, 32'h55, 4'hF, r);
      qclear();
      axi_write(6'h00, 32'h1, 4'hF, r);
      wait_beats(1);
      repeat (5) @(posedge clk);
      chk("len0_count", qd.size(), 1);
      if (qd.size() > 0) begin
         chk("len0_data", qd[0], 32'h55);
         chk("len0_last", ql[0], 1);
      end
      axi_read(6'h0C, d, r);
      chk("len0_status", d, 32'h0002_0000);

      axi_write(6'h04, 32'd8, 4'hF, r);
      axi_write(6'h08, 32'h20, 4'hF, r);
      qclear();
      axi_write(6'h00, 32'h1, 4'hF, r);
      axi_write(6'h00, 32'h1, 4'hF, r);
      repeat (20) @(posedge clk);
      chk("rerun_count", qd.size(), 8);
      for (int i = 0; i < 8 && i < qd.size(); i++) begin
         chk("rerun_data", qd[i], 32'h20 + 32'(i));
         chk("rerun_last", ql[i], i == 7);
      end
      axi_read(6'h0C, d, r);
      chk("rerun_status", d, 32'h0003_0000);

      tready = 1'b0;
      axi_write(6'h04, 32'd3, 4'hF, r);
      axi_write(6'h08, 32'h100, 4'hF, r);
      qclear();
      stab_err = 0;
      mon_stab = 1'b1;
      tog = 1'b1;
      fork
         while (tog) begin @(posedge clk); #1 tready = ~tready; end
      join_none
      axi_write(6'h00, 32'h3, 4'hF, r);
      wait_beats(6);
      @(posedge clk);
      axi_write(6'h00, 32'h6, 4'hF, r);
      repeat (12) @(posedge clk);
      tog = 1'b0;
      mon_stab = 1'b0;
      repeat (2) @(posedge clk);
      #1 tready = 1'b1;
      chk("cont_count", qd.size(), 8);
      for (int i = 0; i < 8 && i < qd.size(); i++) begin
         chk("cont_data", qd[i], exp_d[i]);
         chk("cont_last", ql[i], exp_l[i]);
      end
      begin
         int bad = 0;
         for (int i = 1; i < qc.size(); i++) if (qc[i] - qc[i-1] != 2) bad++;
         chk("cont_no_bubble", bad, 0);
      end
      chk("cont_stable", stab_err, 0);
      axi_read(6'h00, d, r);
      chk("abort_clears_cont", d, 0);
      axi_read(6'h0C, d, r);
      chk("abort_status", d, 32'h0006_0000);

      tready = 1'b0;
      axi_write(6'h04, 32'd10, 4'hF, r);
      axi_write(6'h08, 32'h40, 4'hF, r);
      axi_write(6'h00, 32'h1, 4'hF, r);
      repeat (2) @(posedge clk);
      #1;
      chk("pre_rst_tvalid", tvalid, 1);
      chk("pre_rst_tdata", tdata, 32'h40);
      rst_n = 1'b0;
      #1;
      chk("async_rst_tvalid", tvalid, 0);
      chk("async_rst_tlast", tlast, 0);
      chk("async_rst_tdata", tdata, 0);
      @(posedge clk); #1 rst_n = 1'b1;
      axi_read(6'h0C, d, r);
      chk("rst_status", d, 0);
      axi_read(6'h04, d, r);
      chk("rst_len", d, 0);
      tready = 1'b1;
      axi_write(6'h04, 32'd2, 4'hF, r);
      axi_write(6'h08, 32'h7, 4'hF, r);
      qclear();
      axi_write(6'h00, 32'h1, 4'hF, r);
      wait_beats(2);
      repeat (5) @(posedge clk);
      chk("fresh_count", qd.size(), 2);
      for (int i = 0; i < 2 && i < qd.size(); i++) begin
         chk("fresh_data", qd[i], 32'h7 + 32'(i));
         chk("fresh_last", ql[i], i == 1);
      end
      axi_read(6'h0C, d, r);
      chk("fresh_status", d, 32'h0001_0000);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
